// File: rtl/pc_predict_unit.sv
// Fetch-stage PC selection and next-PC prediction for the pipelined Y86-64 core.
// jXX is predicted taken, call goes to valC, and ret is predicted from a circular return-address stack.
module pc_predict_unit #(
  parameter int unsigned        ADDR_W    = 64,
  parameter int unsigned        RAS_DEPTH = 8,
  parameter bit                 USE_RAS   = 1'b1,
  parameter logic [ADDR_W-1:0]  RESET_PC  = '0
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        stall_f,
  input  logic [3:0]                  f_icode,
  input  logic [ADDR_W-1:0]           f_valC,
  input  logic [ADDR_W-1:0]           f_valP,
  input  logic [3:0]                  m_icode,
  input  logic                        m_cnd,
  input  logic [ADDR_W-1:0]           m_valA,
  input  logic [3:0]                  w_icode,
  input  logic [ADDR_W-1:0]           w_valM,
  input  logic [ADDR_W-1:0]           w_pred,
  output logic [ADDR_W-1:0]           f_pc,
  output logic [ADDR_W-1:0]           pred_pc,
  output logic                        ret_mispredict,
  output logic [$clog2(RAS_DEPTH):0]  ras_count,
  output logic                        ras_underflow
);

  localparam int unsigned PTR_W = $clog2(RAS_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  localparam logic [3:0] ICODE_JXX  = 4'h7;
  localparam logic [3:0] ICODE_CALL = 4'h8;
  localparam logic [3:0] ICODE_RET  = 4'h9;

  logic [ADDR_W-1:0] ras_mem [RAS_DEPTH];
  logic [PTR_W-1:0]  ras_ptr;
  logic [PTR_W-1:0]  ras_ptr_dec;
  logic [ADDR_W-1:0] ras_top;
  logic              ras_empty;
  logic              ras_full;
  logic              is_push;
  logic              is_pop;
  logic              jmp_mis;
  logic [ADDR_W-1:0] pred_next;

  // Redirect detection from M and W
  always_comb begin
    jmp_mis        = (m_icode == ICODE_JXX) && !m_cnd;
    ret_mispredict = (w_icode == ICODE_RET) && (!USE_RAS || (w_valM != w_pred));
  end

  // Fetch address: older jump recovery wins over a ret redirect
  always_comb begin
    f_pc = pred_pc;
    if (jmp_mis) begin
      f_pc = m_valA;
    end else if (ret_mispredict) begin
      f_pc = w_valM;
    end
  end

  // Stack bookkeeping; ras_ptr points at the next free slot, so top is one below it
  always_comb begin
    ras_ptr_dec = ras_ptr - PTR_W'(1);
    ras_top     = ras_mem[ras_ptr_dec];
    ras_empty   = (ras_count == '0);
    ras_full    = (ras_count == CNT_W'(RAS_DEPTH));
    is_push     = !stall_f && (f_icode == ICODE_CALL);
    is_pop      = !stall_f && (f_icode == ICODE_RET);
  end

  // Next prediction from the instruction being fetched now
  always_comb begin
    pred_next = f_valP;
    case (f_icode)
      ICODE_JXX, ICODE_CALL: pred_next = f_valC;
      ICODE_RET: begin
        if (USE_RAS && !ras_empty) begin
          pred_next = ras_top;
        end
      end
      default: pred_next = f_valP;
    endcase
  end

  // Prediction register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pred_pc <= RESET_PC;
    end else if (!stall_f) begin
      pred_pc <= pred_next;
    end
  end

  // Return-address stack; entries are not reset, only pointer and count are
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ras_ptr       <= '0;
      ras_count     <= '0;
      ras_underflow <= 1'b0;
    end else begin
      if (is_push) begin
        ras_mem[ras_ptr] <= f_valP;
        ras_ptr          <= ras_ptr + PTR_W'(1);
        if (!ras_full) begin
          ras_count <= ras_count + CNT_W'(1);
        end
      end else if (is_pop) begin
        if (ras_empty) begin
          ras_underflow <= 1'b1;
        end else begin
          ras_ptr   <= ras_ptr_dec;
          ras_count <= ras_count - CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_pc_predict_unit.sv
// Scoreboard bench for pc_predict_unit: one instance with the RAS enabled, one with it disabled,
// both driven by the same stimulus.
module tb_pc_predict_unit;

  localparam int unsigned ADDR_W = 64;
  localparam logic [ADDR_W-1:0] RPC = 64'h100;

  logic              clk;
  logic              rst_n;
  logic              stall_f;
  logic [3:0]        f_icode, m_icode, w_icode;
  logic [ADDR_W-1:0] f_valC, f_valP, m_valA, w_valM, w_pred;
  logic              m_cnd;

  logic [ADDR_W-1:0] f_pc, pred_pc, f_pc0, pred_pc0;
  logic              ret_mispredict, ras_underflow, ret_mispredict0, ras_underflow0;
  logic [3:0]        ras_count, ras_count0;

  int total = 0;
  int bad   = 0;

  string             tag_q[$];
  int                sig_q[$];
  logic [63:0]       exp_q[$];

  localparam int S_PRED = 0, S_FPC = 1, S_CNT = 2, S_RMIS = 3, S_UNDF = 4,
                 S_PRED0 = 5, S_FPC0 = 6, S_RMIS0 = 7;

  pc_predict_unit #(.ADDR_W(ADDR_W), .RAS_DEPTH(8), .USE_RAS(1'b1), .RESET_PC(RPC)) dut (
    .clk(clk), .rst_n(rst_n), .stall_f(stall_f),
    .f_icode(f_icode), .f_valC(f_valC), .f_valP(f_valP),
    .m_icode(m_icode), .m_cnd(m_cnd), .m_valA(m_valA),
    .w_icode(w_icode), .w_valM(w_valM), .w_pred(w_pred),
    .f_pc(f_pc), .pred_pc(pred_pc), .ret_mispredict(ret_mispredict),
    .ras_count(ras_count), .ras_underflow(ras_underflow)
  );

  pc_predict_unit #(.ADDR_W(ADDR_W), .RAS_DEPTH(8), .USE_RAS(1'b0), .RESET_PC(RPC)) dut0 (
    .clk(clk), .rst_n(rst_n), .stall_f(stall_f),
    .f_icode(f_icode), .f_valC(f_valC), .f_valP(f_valP),
    .m_icode(m_icode), .m_cnd(m_cnd), .m_valA(m_valA),
    .w_icode(w_icode), .w_valM(w_valM), .w_pred(w_pred),
    .f_pc(f_pc0), .pred_pc(pred_pc0), .ret_mispredict(ret_mispredict0),
    .ras_count(ras_count0), .ras_underflow(ras_underflow0)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] observe(input int sig);
    case (sig)
      S_PRED:  return pred_pc;
      S_FPC:   return f_pc;
      S_CNT:   return 64'(ras_count);
      S_RMIS:  return 64'(ret_mispredict);
      S_UNDF:  return 64'(ras_underflow);
      S_PRED0: return pred_pc0;
      S_FPC0:  return f_pc0;
      S_RMIS0: return 64'(ret_mispredict0);
      default: return 64'hx;
    endcase
  endfunction

  task automatic expect_out(input string tag, input int sig, input logic [63:0] val);
    tag_q.push_back(tag);
    sig_q.push_back(sig);
    exp_q.push_back(val);
  endtask

  task automatic drain();
    while (tag_q.size() > 0) begin
      string       t;
      int          s;
      logic [63:0] e;
      t = tag_q.pop_front();
      s = sig_q.pop_front();
      e = exp_q.pop_front();
      check(t, observe(s), e);
    end
  endtask

  // Outputs are sampled 1 ns after the rising edge, or 1 ns after driving combinational inputs
  task automatic tick();
    @(posedge clk);
    #1;
    drain();
  endtask

  task automatic settle();
    #1;
    drain();
  endtask

  task automatic fetch(input logic [3:0] ic, input logic [63:0] vc, input logic [63:0] vp);
    f_icode = ic;
    f_valC  = vc;
    f_valP  = vp;
  endtask

  initial begin
    rst_n   = 1'b0;
    stall_f = 1'b0;
    fetch(4'h1, 64'h0, 64'h0);
    m_icode = 4'h1; m_cnd = 1'b1; m_valA = '0;
    w_icode = 4'h1; w_valM = '0; w_pred = '0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    expect_out("rst_pred", S_PRED, RPC);
    expect_out("rst_fpc", S_FPC, RPC);
    expect_out("rst_cnt", S_CNT, 0);
    expect_out("rst_undf", S_UNDF, 0);
    expect_out("rst_rmis", S_RMIS, 0);
    drain();
    rst_n = 1'b1;

    // nop falls through
    fetch(4'h1, 64'h0, 64'h101);
    expect_out("nop_fpc_before", S_FPC, RPC);
    settle();
    expect_out("nop_pred", S_PRED, 64'h101);
    tick();

    // jXX predicted taken, then recovered from M
    fetch(4'h7, 64'h200, 64'h109);
    expect_out("jxx_pred", S_PRED, 64'h200);
    expect_out("jxx_fpc", S_FPC, 64'h200);
    tick();
    fetch(4'h1, 64'h0, 64'h201);
    expect_out("jxx_next_pred", S_PRED, 64'h201);
    tick();
    m_icode = 4'h7; m_cnd = 1'b0; m_valA = 64'h109;
    fetch(4'h1, 64'h0, 64'h10A);
    expect_out("jmis_fpc", S_FPC, 64'h109);
    settle();
    expect_out("jmis_after_pred", S_PRED, 64'h10A);
    tick();
    m_icode = 4'h1; m_cnd = 1'b1;

    // call/ret via RAS, then correct W ret
    fetch(4'h8, 64'h500, 64'h40A);
    expect_out("call_pred", S_PRED, 64'h500);
    expect_out("call_cnt", S_CNT, 1);
    tick();
    fetch(4'h9, 64'h0, 64'h501);
    expect_out("ret_pred", S_PRED, 64'h40A);
    expect_out("ret_cnt", S_CNT, 0);
    tick();
    fetch(4'h1, 64'h0, 64'h40B);
    w_icode = 4'h9; w_valM = 64'h40A; w_pred = 64'h40A;
    expect_out("wret_ok_rmis", S_RMIS, 0);
    expect_out("wret_ok_fpc", S_FPC, 64'h40A);
    expect_out("wret_noras_rmis", S_RMIS0, 1);
    expect_out("wret_noras_fpc", S_FPC0, 64'h40A);
    settle();
    tick();
    w_icode = 4'h1;

    // Overflow: nine pushes into eight entries
    for (int i = 0; i < 9; i++) begin
      fetch(4'h8, 64'h1000 + 64'(i), 64'h10 + 64'(i));
      expect_out($sformatf("ovf_call%0d_pred", i), S_PRED, 64'h1000 + 64'(i));
      expect_out($sformatf("ovf_call%0d_cnt", i), S_CNT, (i < 8) ? 64'(i + 1) : 64'd8);
      tick();
    end
    for (int j = 0; j < 8; j++) begin
      fetch(4'h9, 64'h0, 64'h2000 + 64'(j));
      expect_out($sformatf("ovf_ret%0d_pred", j), S_PRED, 64'h18 - 64'(j));
      expect_out($sformatf("ovf_ret%0d_cnt", j), S_CNT, 64'(7 - j));
      expect_out($sformatf("ovf_ret%0d_undf", j), S_UNDF, 0);
      tick();
    end
    fetch(4'h9, 64'h0, 64'h3000);
    expect_out("undf_pred", S_PRED, 64'h3000);
    expect_out("undf_flag", S_UNDF, 1);
    expect_out("undf_cnt", S_CNT, 0);
    tick();

    // Priority and stall
    fetch(4'h8, 64'h700, 64'h44);
    expect_out("pre_stall_pred", S_PRED, 64'h700);
    expect_out("pre_stall_cnt", S_CNT, 1);
    tick();
    stall_f = 1'b1;
    fetch(4'h8, 64'h900, 64'h55);
    m_icode = 4'h7; m_cnd = 1'b0; m_valA = 64'h300;
    w_icode = 4'h9; w_valM = 64'h600; w_pred = 64'h5FF;
    expect_out("both_fpc", S_FPC, 64'h300);
    expect_out("both_rmis", S_RMIS, 1);
    settle();
    expect_out("stall_pred", S_PRED, 64'h700);
    expect_out("stall_cnt", S_CNT, 1);
    tick();
    m_icode = 4'h1; m_cnd = 1'b1;
    expect_out("retmis_fpc", S_FPC, 64'h600);
    expect_out("undf_sticky", S_UNDF, 1);
    settle();
    stall_f = 1'b0;
    w_icode = 4'h1;

    // USE_RAS=0 alongside the RAS-enabled instance
    fetch(4'h9, 64'h0, 64'h801);
    expect_out("noras_ret_pred", S_PRED0, 64'h801);
    expect_out("ras_ret_pred", S_PRED, 64'h44);
    expect_out("ras_ret_cnt", S_CNT, 0);
    tick();
    fetch(4'h1, 64'h0, 64'h802);
    w_icode = 4'h9; w_valM = 64'h900; w_pred = 64'h900;
    expect_out("noras_wret_rmis", S_RMIS0, 1);
    expect_out("noras_wret_fpc", S_FPC0, 64'h900);
    expect_out("ras_wret_rmis", S_RMIS, 0);
    expect_out("ras_wret_fpc", S_FPC, 64'h44);
    settle();
    tick();
    w_icode = 4'h1;

    // Async reset mid-cycle with a call pending
    fetch(4'h8, 64'hA00, 64'hA0A);
    #2;
    rst_n = 1'b0;
    expect_out("areset_pred", S_PRED, RPC);
    expect_out("areset_pred0", S_PRED0, RPC);
    expect_out("areset_cnt", S_CNT, 0);
    expect_out("areset_undf", S_UNDF, 0);
    expect_out("areset_fpc", S_FPC, RPC);
    settle();
    expect_out("areset_hold_cnt", S_CNT, 0);
    expect_out("areset_hold_pred", S_PRED, RPC);
    tick();
    rst_n = 1'b1;
    #20;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pc_predict_unit.md
# pc_predict_unit

Fetch-stage PC selection and prediction block for the pipelined Y86-64 processor. It holds the predicted-PC register and selects each cycle's fetch address from the prediction, a memory-stage jump-mispredict recovery or a writeback-stage return target. Prediction is always-taken for jXX, valC for call, and, when enabled, a return-address stack (RAS) for ret. It also flags ret mispredictions to pipeline control.

## Interface
- ADDR_W, 64: address width; all PC/val buses are this width.
- RAS_DEPTH, 8: return-address stack entries (power of two, ≥2).
- USE_RAS, 1: 1 = ret predicted from RAS; 0 = ret predicts valP and always redirects at writeback.
- RESET_PC, 0: value of pred_pc after reset.

- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- stall_f  in  1  hold fetch: pred_pc and RAS unchanged.
- f_icode  in  4  icode of the instruction fetched at f_pc this cycle.
- f_valC  in  ADDR_W  fetch-stage constant (jump/call target).
- f_valP  in  ADDR_W  fetch-stage fall-through PC.
- m_icode  in  4  memory-stage icode.
- m_cnd  in  1  memory-stage branch condition.
- m_valA  in  ADDR_W  memory-stage fall-through of jXX (recovery PC).
- w_icode  in  4  writeback-stage icode.
- w_valM  in  ADDR_W  actual return address loaded by ret.
- w_pred  in  ADDR_W  PC predicted after that ret, carried down the pipe.
- f_pc  out  ADDR_W  fetch address, combinational.
- pred_pc  out  ADDR_W  registered prediction.
- ret_mispredict  out  1  combinational: ret in W with wrong prediction.
- ras_count  out  $clog2(RAS_DEPTH)+1  valid RAS entries.
- ras_underflow  out  1  sticky: pop attempted on empty RAS.

## Operation
- Icodes: jXX = 4'h7, call = 4'h8, ret = 4'h9.
- jmp_mis = (m_icode==7) && !m_cnd.
- ret_mispredict = (w_icode==9) && (USE_RAS==0 || w_valM != w_pred).
- f_pc priority:
  1. jmp_mis → m_valA.
  2. else ret_mispredict → w_valM.
  3. else pred_pc.
- Next prediction from f_icode:
  - jXX or call → f_valC.
  - ret with USE_RAS=1 and ras_count>0 → RAS top.
  - all other cases, including ret on an empty RAS or with USE_RAS=0 → f_valP.
- RAS is updated only when !stall_f:
  - call pushes f_valP.
  - ret pops.
  - push when full overwrites the oldest entry (circular); ras_count saturates at RAS_DEPTH.
  - pop when empty leaves state unchanged and sets ras_underflow.
- No RAS repair on squash. Wrong-path pushes and pops persist and are caught by ret_mispredict.
- Widths: all addresses are ADDR_W with no arithmetic. The pointer wraps modulo RAS_DEPTH.

## Timing
- Reset (async assert, sync release): pred_pc=RESET_PC, ras_count=0, RAS pointer=0, ras_underflow=0, RAS contents undefined.
  - Outputs after reset: f_pc=RESET_PC; ret_mispredict follows its inputs combinationally.
- Reset asserted mid-operation aborts any push/pop on that edge.
- f_pc and ret_mispredict: zero latency from their inputs.
- pred_pc and RAS: update on the rising clk edge when !stall_f, one cycle after f_icode is presented; held when stall_f=1.
- jmp_mis and ret_mispredict still override f_pc while stalled. The external controller is responsible for not stalling on a redirect cycle.
- Simultaneous jmp_mis and ret_mispredict: jmp_mis wins. The ret is on an older path and is handled by external bubbling.

## Test plan
1. Reset with RESET_PC=0x100, no stall:
   - f_pc=0x100 after reset.
   - f_icode=1 (nop), f_valP=0x101 → pred_pc=0x101 after one edge.
2. jXX prediction and recovery:
   - f_icode=7, f_valC=0x200, f_valP=0x109 → pred_pc=0x200.
   - Two cycles later m_icode=7, m_cnd=0, m_valA=0x109 → f_pc=0x109 that cycle.
3. call/ret via RAS:
   - call at f_valP=0x40A, f_valC=0x500 → pred_pc=0x500, ras_count=1.
   - ret fetched → pred_pc=0x40A, ras_count=0.
   - W ret with w_valM=0x40A, w_pred=0x40A → ret_mispredict=0.
4. RAS overflow (RAS_DEPTH=8):
   - Nine calls pushing 0x10..0x18 → ras_count=8.
   - Eight rets predict 0x18 down to 0x11.
   - Ninth ret predicts its f_valP and sets ras_underflow=1.
5. Priority and stall:
   - stall_f=1 with f_icode=8 → pred_pc and ras_count unchanged.
   - Same cycle jmp_mis (m_valA=0x300) and W ret mismatch (w_valM=0x600) → f_pc=0x300, ret_mispredict=1.
6. USE_RAS=0:
   - ret fetched → pred_pc=f_valP.
   - W ret → ret_mispredict=1 and f_pc=w_valM.
   - Async rst_n pulse mid-sequence → pred_pc=RESET_PC immediately, ras_count=0.
